// File: rtl/jk_bank_pkg.sv
// Shared op codes and FSM state encodings for the JK flip-flop bank sequencer.
package jk_bank_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_UP     = 2'b01,
    OP_DOWN   = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/jk_excite.sv
// JK excitation for a whole bank: set bits rising to n, clear bits falling, hold the rest.
module jk_excite #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  always_comb begin
    j = n & ~q;
    k = ~n & q;
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer driving J/K of a flip-flop bank (LOAD / UP / DOWN / TOGGLE).
// Optional abort input and aborted flag when JK_BANK_CTRL_ABORT_EN is defined.
module jk_bank_ctrl
  import jk_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
`ifdef JK_BANK_CTRL_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LEN_W-1:0] rem_q, rem_d;
`ifdef JK_BANK_CTRL_ABORT_EN
  logic             aborted_q, aborted_d;
`endif

  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] j_ex, k_ex;

  // Per-cycle target follows the live bank state so UP/DOWN track what the bank really holds.
  always_comb begin
    unique case (op_q)
      OP_LOAD: target = data_q;
      OP_UP:   target = q_i + WIDTH'(1);
      OP_DOWN: target = q_i - WIDTH'(1);
      default: target = q_i;
    endcase
  end

  jk_excite #(
    .WIDTH(WIDTH)
  ) u_excite (
    .n(target),
    .q(q_i),
    .j(j_ex),
    .k(k_ex)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    rem_d     = rem_q;
    cmd_ready = 1'b0;
    busy      = (state_q != ST_IDLE);
    done      = 1'b0;
    j_o       = '0;
    k_o       = '0;
`ifdef JK_BANK_CTRL_ABORT_EN
    aborted_d = aborted_q;
    aborted   = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d   = op_e'(cmd_op);
          data_d = cmd_data;
          if (op_e'(cmd_op) == OP_LOAD) begin
            rem_d   = LEN_W'(1);
            state_d = ST_RUN;
          end else if (cmd_len != '0) begin
            rem_d   = cmd_len;
            state_d = ST_RUN;
          end else begin
            rem_d   = '0;
            state_d = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        rem_d = rem_q - LEN_W'(1);
        if (op_q == OP_TOGGLE) begin
          j_o = data_q;
          k_o = data_q;
        end else begin
          j_o = j_ex;
          k_o = k_ex;
        end
        if (rem_q == LEN_W'(1)) begin
          state_d = ST_DONE;
        end
`ifdef JK_BANK_CTRL_ABORT_EN
        // Abort masks excitation in the same cycle so the bank freezes at this edge.
        if (abort) begin
          j_o       = '0;
          k_o       = '0;
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end
`endif
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
`ifdef JK_BANK_CTRL_ABORT_EN
        aborted   = aborted_q;
        aborted_d = 1'b0;
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LOAD;
      data_q    <= '0;
      rem_q     <= '0;
`ifdef JK_BANK_CTRL_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      rem_q     <= rem_d;
`ifdef JK_BANK_CTRL_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Scoreboard bench for jk_bank_ctrl with a JK flip-flop bank closed in the loop.
// Covers the abort path when JK_BANK_CTRL_ABORT_EN is defined.
module tb_jk_bank_ctrl;

  localparam int CK_SEMIPERIOD = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_len;
  logic [3:0] q;
  logic [3:0] j_o, k_o;
  logic       busy, done;
`ifdef JK_BANK_CTRL_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Expected bank value after each update, and per-command completion records.
  logic [3:0] exp_q[$];
  int         exp_steps[$];
  logic [3:0] exp_final[$];
  logic [3:0] model_q;
  logic [1:0] cur_op;
  logic [3:0] cur_mask;
  bit         sb_en;

  always #CK_SEMIPERIOD clk = ~clk;

  jk_bank_ctrl #(
    .WIDTH(4),
    .LEN_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cmd_len  (cmd_len),
`ifdef JK_BANK_CTRL_ABORT_EN
    .abort    (abort),
    .aborted  (aborted),
`endif
    .q_i      (q),
    .j_o      (j_o),
    .k_o      (k_o),
    .busy     (busy),
    .done     (done)
  );

  // The flip-flop bank: JK characteristic equation, async reset shared with the controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= (j_o & ~q) | (~k_o & q);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] step(input logic [1:0] op, input logic [3:0] d,
                                      input logic [3:0] cur);
    case (op)
      2'b00:   return d;
      2'b01:   return cur + 4'd1;
      2'b10:   return cur - 4'd1;
      default: return cur ^ d;
    endcase
  endfunction

  // Monitor: pops one expected value per bank update and one record per done pulse.
  bit         run_prev = 1'b0;
  int         run_cnt  = 0;
  always @(negedge clk) begin
    if (!rst_n || !sb_en) begin
      run_prev = 1'b0;
      run_cnt  = 0;
    end else begin
      bit in_run;
      if (run_prev) begin
        if (exp_q.size() == 0) chk("q_underflow", 32'd0, 32'd1);
        else                   chk("q_step", {28'd0, q}, {28'd0, exp_q.pop_front()});
      end
      in_run = busy && !done;
      if (in_run) begin
        run_cnt++;
        if (cur_op == 2'b11) begin
          chk("toggle_j", {28'd0, j_o}, {28'd0, cur_mask});
          chk("toggle_k", {28'd0, k_o}, {28'd0, cur_mask});
        end else begin
          chk("jk_overlap", {28'd0, j_o & k_o}, 32'd0);
          if (exp_q.size() > 0)
            chk("jk_reaches_target", {28'd0, (j_o & ~q) | (~k_o & q)}, {28'd0, exp_q[0]});
        end
      end
      if (done) begin
        if (exp_steps.size() == 0) begin
          chk("done_unexpected", 32'd0, 32'd1);
        end else begin
          chk("run_cycles", run_cnt, exp_steps.pop_front());
          chk("final_q", {28'd0, q}, {28'd0, exp_final.pop_front()});
        end
        run_cnt = 0;
      end
      run_prev = in_run;
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic issue(input logic [1:0] op, input logic [3:0] d, input logic [7:0] len,
                       output int waits);
    int steps;
    steps = (op == 2'b00) ? 1 : int'(len);
    for (int i = 0; i < steps; i++) begin
      model_q = step(op, d, model_q);
      exp_q.push_back(model_q);
    end
    exp_steps.push_back(steps);
    exp_final.push_back(model_q);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_len   = len;
    waits     = 0;
    while (!cmd_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!cmd_ready) begin
      $display("FAIL accept_timeout: got ready=0 expected ready=1");
      n_err++;
      n_cmp++;
    end
    @(posedge clk);
    #1;
    cur_op    = op;
    cur_mask  = d;
    cmd_valid = 1'b0;
    cmd_data  = 4'($urandom);
    cmd_len   = 8'($urandom);
    cmd_op    = 2'($urandom);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int w;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    cmd_len   = '0;
    model_q   = '0;
    cur_op    = '0;
    cur_mask  = '0;
    sb_en     = 1'b1;
`ifdef JK_BANK_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_jk", {24'd0, j_o, k_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);

    // 1: LOAD A from q=0
    issue(2'b00, 4'hA, 8'd0, w);
    chk("load_j", {28'd0, j_o}, 32'hA);
    chk("load_k", {28'd0, k_o}, 32'h0);
    wait_idle();

    // 2: UP len 3 from E wraps through 0
    issue(2'b00, 4'hE, 8'd0, w);
    wait_idle();
    issue(2'b01, 4'h0, 8'd3, w);
    wait_idle();

    // 3: DOWN len 2 from 1 wraps to F
    issue(2'b10, 4'h0, 8'd2, w);
    chk("down_j", {28'd0, j_o}, 32'h0);
    chk("down_k", {28'd0, k_o}, 32'h1);
    wait_idle();

    // 4: TOGGLE mask 3 from 5
    issue(2'b00, 4'h5, 8'd0, w);
    wait_idle();
    issue(2'b11, 4'h3, 8'd4, w);
    chk("tog_j", {28'd0, j_o}, 32'h3);
    wait_idle();

    // 5: UP len 0, with a second command held through DONE
    issue(2'b01, 4'h0, 8'd0, w);
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_ready", {31'd0, cmd_ready}, 32'd0);
    issue(2'b00, 4'h7, 8'd0, w);
    chk("held_accept_waits", w, 32'd1);
    wait_idle();

    // 6: reset in the fourth RUN cycle of UP len 10
    issue(2'b01, 4'h0, 8'd10, w);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", {28'd0, q}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_jk", {24'd0, j_o, k_o}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    exp_q.delete();
    exp_steps.delete();
    exp_final.delete();
    model_q = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_done", {31'd0, done}, 32'd0);

`ifdef JK_BANK_CTRL_ABORT_EN
    sb_en = 1'b0;
    issue(2'b01, 4'h0, 8'd10, w);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort_jk", {24'd0, j_o, k_o}, 32'd0);
    @(negedge clk);
    chk("abort_done", {31'd0, done}, 32'd1);
    chk("abort_flag", {31'd0, aborted}, 32'd1);
    chk("abort_q", {28'd0, q}, 32'd4);
    abort = 1'b0;
    wait_idle();
    exp_q.delete();
    exp_steps.delete();
    exp_final.delete();
    model_q = 4'd4;
    sb_en   = 1'b1;
    issue(2'b01, 4'h0, 8'd1, w);
    wait_idle();
    chk("no_abort_flag", {31'd0, aborted}, 32'd0);
`endif

    // Randomised back-to-back commands
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom), 4'($urandom), 8'($urandom_range(0, 6)), w);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("exp_done_drained", exp_steps.size(), 32'd0);
    chk("final_model_q", {28'd0, q}, {28'd0, model_q});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
